rcv_timer: RTL

RCV_TIMER -- requirements
Module: rcv_timer

---
 rtl/rcv_pkg.sv | 14 +
 rtl/rcv_timer.sv | 109 ++++++++++
 2 files changed

// File: rtl/rcv_pkg.sv
// Shared types and constants for the receive bit timer.
package rcv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } rcv_state_e;

  localparam int unsigned NUM_BITS_DEFAULT = 9;
  localparam int unsigned MIN_PERIOD       = 2;

endpackage

// File: rtl/rcv_timer.sv
// Receive bit timer: mid-bit shift strobes and an end-of-packet pulse for a serial receiver.
module rcv_timer
  import rcv_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned NUM_BITS     = NUM_BITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_timer,
  input  logic                    clear,
  input  logic [NUM_CNT_BITS-1:0] bit_period,
  output logic                    shift_strobe,
  output logic                    packet_done,
  output logic [3:0]              bit_index,
  output logic                    busy
);

  localparam logic [NUM_CNT_BITS-1:0] MinP     = NUM_CNT_BITS'(MIN_PERIOD);
  localparam logic [NUM_CNT_BITS-1:0] CntOne   = NUM_CNT_BITS'(1);
  localparam logic [3:0]              LastIdx  = 4'(NUM_BITS - 1);

  rcv_state_e              state_q, state_d;
  logic [NUM_CNT_BITS-1:0] clk_cnt_q, clk_cnt_d;
  logic [NUM_CNT_BITS-1:0] period_q, period_d;
  logic [3:0]              bit_idx_q, bit_idx_d;
  logic                    strobe;

  // Periods below 2 would put the strobe on the wrap cycle; clamp them.
  function automatic logic [NUM_CNT_BITS-1:0] clamp_period(input logic [NUM_CNT_BITS-1:0] p);
    return (p < MinP) ? MinP : p;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      period_q  <= MinP;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      period_q  <= period_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    period_d  = period_q;

    strobe       = (state_q == COUNT) && (clk_cnt_q == (period_q >> 1));
    shift_strobe = strobe;
    packet_done  = (state_q == DONE);
    busy         = (state_q != IDLE);
    bit_index    = bit_idx_q;

    if (clear) begin
      state_d   = IDLE;
      clk_cnt_d = '0;
      bit_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          if (enable_timer) begin
            state_d  = COUNT;
            period_d = clamp_period(bit_period);
          end
        end
        COUNT: begin
          if (!enable_timer) begin
            state_d   = IDLE;
            clk_cnt_d = '0;
            bit_idx_d = '0;
          end else begin
            clk_cnt_d = (clk_cnt_q == period_q - CntOne) ? '0 : clk_cnt_q + CntOne;
            if (strobe) begin
              bit_idx_d = bit_idx_q + 4'd1;
              if (bit_idx_q == LastIdx) begin
                state_d   = DONE;
                clk_cnt_d = '0;
              end
            end
          end
        end
        DONE: begin
          // bit_index reads NUM_BITS only during the done pulse.
          state_d   = HOLD;
          bit_idx_d = '0;
        end
        HOLD: begin
          if (!enable_timer) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end
      endcase
    end
  end

endmodule
